// File: rtl/mem_access_master.sv
// Initiator for the dual-address registered-read memory macro: one client request at a
// time, single-cycle strobes, and read data un-swapped for upper-half addresses.
module mem_access_master #(
  parameter int WIDTH      = 16,
  parameter int PSIZE      = 4,
  parameter int DEPTH      = 2**PSIZE,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [PSIZE-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam int HW = WIDTH / 2;
  localparam logic [PSIZE-1:0] SWAP_BASE = PSIZE'(DEPTH / 2);

  typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD, RESP} state_t;

  state_t           state, state_next;
  logic [PSIZE-1:0] addr_q, addr_next;
  logic [CW-1:0]    cnt_q, cnt_next;

  logic             mem_wr_next, mem_rd_next;
  logic [PSIZE-1:0] mem_wr_addr_next, mem_rd_addr_next;
  logic [WIDTH-1:0] mem_wdata_next;
  logic             rsp_valid_next, rsp_wr_next;
  logic [WIDTH-1:0] rsp_rdata_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready depends only on state; rsp_valid/rsp_wr/rsp_rdata hold until rsp_ready is seen.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next       = state;
    addr_next        = addr_q;
    cnt_next         = cnt_q;
    mem_wr_next      = 1'b0;
    mem_rd_next      = 1'b0;
    mem_wr_addr_next = mem_wr_addr;
    mem_rd_addr_next = mem_rd_addr;
    mem_wdata_next   = mem_wdata;
    rsp_valid_next   = rsp_valid;
    rsp_wr_next      = rsp_wr;
    rsp_rdata_next   = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_next = req_addr;
          if (req_wr) begin
            state_next       = ISSUE_WR;
            mem_wr_next      = 1'b1;
            mem_wr_addr_next = req_addr;
            mem_wdata_next   = req_wdata;
          end else begin
            state_next       = ISSUE_RD;
            mem_rd_next      = 1'b1;
            mem_rd_addr_next = req_addr;
          end
        end
      end
      ISSUE_WR: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_wr_next    = 1'b1;
        rsp_rdata_next = '0;
      end
      ISSUE_RD: begin
        state_next = WAIT_RD;
        cnt_next   = CW'(RD_LATENCY);
      end
      WAIT_RD: begin
        if (cnt_q == CW'(1)) begin
          state_next     = RESP;
          cnt_next       = '0;
          rsp_valid_next = 1'b1;
          rsp_wr_next    = 1'b0;
          // The memory stores upper-half words half-swapped; swap back for the client.
          if (addr_q >= SWAP_BASE)
            rsp_rdata_next = {mem_rdata[HW-1:0], mem_rdata[WIDTH-1:HW]};
          else
            rsp_rdata_next = mem_rdata;
        end else begin
          cnt_next = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_next;
      addr_q      <= addr_next;
      cnt_q       <= cnt_next;
      mem_wr      <= mem_wr_next;
      mem_rd      <= mem_rd_next;
      mem_wr_addr <= mem_wr_addr_next;
      mem_rd_addr <= mem_rd_addr_next;
      mem_wdata   <= mem_wdata_next;
      rsp_valid   <= rsp_valid_next;
      rsp_wr      <= rsp_wr_next;
      rsp_rdata   <= rsp_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: behavioural swap memory, table-driven write/read pairs,
// scoreboard-checked random traffic, stall, latency and mid-operation reset sequences.
module tb_mem_access_master;

  logic        clk;
  logic        rst_n;

  // Main DUT, RD_LATENCY = 1
  logic        req_valid, req_ready, req_wr;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_wr;
  logic [15:0] rsp_rdata;
  logic        mem_wr, mem_rd;
  logic [3:0]  mem_wr_addr, mem_rd_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy;

  // Second DUT, RD_LATENCY = 3
  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [3:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_wr;
  logic [15:0] b_rsp_rdata;
  logic        b_mem_wr, b_mem_rd;
  logic [3:0]  b_mem_wr_addr, b_mem_rd_addr;
  logic [15:0] b_mem_wdata, b_mem_rdata;
  logic        b_busy;

  mem_access_master #(.WIDTH(16), .PSIZE(4), .RD_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_access_master #(.WIDTH(16), .PSIZE(4), .RD_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_wr(b_rsp_wr), .rsp_rdata(b_rsp_rdata),
    .mem_wr(b_mem_wr), .mem_rd(b_mem_rd), .mem_wr_addr(b_mem_wr_addr), .mem_rd_addr(b_mem_rd_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory models ----------------
  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] rd0, r1a, r1b, r1c;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem0[i] <= '0;
      rd0 <= '0;
    end else begin
      if (mem_wr) mem0[mem_wr_addr] <= (mem_wr_addr >= 4'd8) ? swap16(mem_wdata) : mem_wdata;
      if (mem_rd) rd0 <= mem0[mem_rd_addr];
    end
  end
  assign mem_rdata = rd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem1[i] <= '0;
      r1a <= '0; r1b <= '0; r1c <= '0;
    end else begin
      if (b_mem_wr) mem1[b_mem_wr_addr] <= (b_mem_wr_addr >= 4'd8) ? swap16(b_mem_wdata) : b_mem_wdata;
      if (b_mem_rd) r1a <= mem1[b_mem_rd_addr];
      r1b <= r1a;
      r1c <= r1b;
    end
  end
  assign b_mem_rdata = r1c;

  // ---------------- strobe monitor ----------------
  int overlap_cnt = 0;
  int wr_pulses   = 0;
  int rd_pulses   = 0;
  logic [15:0] last_wdata = '0;

  always @(negedge clk) begin
    if (mem_wr && mem_rd) overlap_cnt++;
    if (mem_wr) begin wr_pulses++; last_wdata = mem_wdata; end
    if (mem_rd) rd_pulses++;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [15:0] shadow [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    exp_q.delete();
  endtask

  task automatic send(input logic wr, input logic [3:0] a, input logic [15:0] d);
    bit acc;
    int n;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    exp_q.push_back(wr ? {1'b1, 16'h0000} : {1'b0, shadow[a]});
    if (wr) shadow[a] = d;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    check("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input bit rnd, output int lat, output logic [15:0] rdata);
    logic [16:0] exp;
    bit done;
    int cyc;
    done = 0; cyc = 0; lat = -1; rdata = '0;
    while (!done && cyc < 100) begin
      rsp_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      @(negedge clk);
      if (rsp_valid && lat < 0) lat = cyc;
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("rsp_wr_rdata", {15'b0, rsp_wr, rsp_rdata}, {15'b0, exp});
        end
        rdata = rsp_rdata;
        done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b0;
    check("rsp_seen", 32'(done), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_mem;
    logic [15:0] exp_rdata;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, w0, r0, n, quiet;
    bit acc, seen;
    logic [15:0] rd;

    tbl[0] = '{4'd3,  16'hABCD, 16'hABCD, 16'hABCD};
    tbl[1] = '{4'd9,  16'h1234, 16'h3412, 16'h1234};
    tbl[2] = '{4'd7,  16'h1234, 16'h1234, 16'h1234};
    tbl[3] = '{4'd8,  16'h1234, 16'h3412, 16'h1234};
    tbl[4] = '{4'd15, 16'h1234, 16'h3412, 16'h1234};
    tbl[5] = '{4'd0,  16'h00FF, 16'h00FF, 16'h00FF};
    tbl[6] = '{4'd12, 16'hBEEF, 16'hEFBE, 16'hBEEF};

    req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    b_req_valid = 0; b_req_wr = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_wr", 32'(rsp_wr), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;

    // read right after reset: zero data, 2-cycle accept-to-valid
    send(1'b0, 4'd5, 16'h0);
    wait_rsp(1'b0, lat, rd);
    check("rst_read_rdata", 32'(rd), 32'd0);
    check("rd_latency_1", 32'(lat), 32'd2);

    // RD_LATENCY = 3 instance: 4-cycle accept-to-valid
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 4'd5;
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = b_req_ready;
      @(posedge clk); #1; n++;
    end
    b_req_valid = 1'b0;
    check("b_req_accept", 32'(acc), 32'd1);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (b_rsp_valid) seen = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    check("rd_latency_3", 32'(lat), 32'd4);
    check("b_rsp_rdata", 32'(b_rsp_rdata), 32'd0);
    check("b_rsp_wr", 32'(b_rsp_wr), 32'd0);
    @(posedge clk); #1;

    // table: write then read at each address
    for (int i = 0; i < NV; i++) begin
      w0 = wr_pulses;
      send(1'b1, tbl[i].addr, tbl[i].wdata);
      wait_rsp(1'b0, lat, rd);
      if (i == 0) check("wr_latency", 32'(lat), 32'd1);
      check($sformatf("wr_pulse[%0d]", i), 32'(wr_pulses - w0), 32'd1);
      check($sformatf("mem_wdata[%0d]", i), 32'(last_wdata), 32'(tbl[i].wdata));
      check($sformatf("mem_content[%0d]", i), 32'(mem0[tbl[i].addr]), 32'(tbl[i].exp_mem));
      send(1'b0, tbl[i].addr, 16'h0);
      wait_rsp(1'b0, lat, rd);
      check($sformatf("rdata[%0d]", i), 32'(rd), 32'(tbl[i].exp_rdata));
    end

    // response stall on a read of addr 3
    send(1'b0, 4'd3, 16'h0);
    rsp_ready = 1'b0; seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else begin @(posedge clk); #1; n++; end
    end
    check("stall_rsp_seen", 32'(seen), 32'd1);
    w0 = wr_pulses; r0 = rd_pulses;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", 32'(rsp_rdata), 32'hABCD);
      check("stall_rsp_wr", 32'(rsp_wr), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    check("stall_no_strobes", 32'((wr_pulses - w0) + (rd_pulses - r0)), 32'd0);
    @(posedge clk); #1;
    wait_rsp(1'b0, lat, rd);

    // random traffic with response stalls
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
      wait_rsp(1'b1, lat, rd);
    end
    check("wr_rd_overlap", 32'(overlap_cnt), 32'd0);

    // reset during WAIT_RD
    send(1'b1, 4'd6, 16'h5555);
    wait_rsp(1'b0, lat, rd);
    send(1'b0, 4'd6, 16'h0);
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_mem_rd", 32'(mem_rd), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) quiet++;
    end
    check("midrst_no_rsp", 32'(quiet), 32'd0);
    @(posedge clk); #1;
    send(1'b0, 4'd6, 16'h0);
    wait_rsp(1'b0, lat, rd);
    check("post_rst_read", 32'(rd), 32'd0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    check("wr_rd_overlap_final", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator-side controller for the dual-address, single-clock memory macro with registered read data, in_wr/in_rd strobes and upper-half byte swapping.
- Accepts one client request at a time over a valid/ready handshake and drives the memory's write and read strobes, addresses and data.
- Captures the registered read data after the configured latency and undoes the half-swap for upper-half addresses, so the client reads back exactly what it wrote.
- Returns the result over a valid/ready response channel.

Parameters:
WIDTH, 16, data word width; must be even (half-swap boundary WIDTH/2)
PSIZE, 4, address width
DEPTH, 2**PSIZE, number of memory words; swap region is addr >= DEPTH/2
RD_LATENCY, 1, cycles from the mem_rd cycle to mem_rdata valid; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  client request valid
req_ready  output  1  master can accept a request
req_wr  input  1  1 = write, 0 = read
req_addr  input  PSIZE  request word address
req_wdata  input  WIDTH  write data, unswapped client view
rsp_valid  output  1  response valid
rsp_ready  input  1  client accepts response
rsp_wr  output  1  response type: 1 = write ack, 0 = read data
rsp_rdata  output  WIDTH  read data, client view; 0 for write acks
mem_wr  output  1  memory write strobe (drives in_wr)
mem_rd  output  1  memory read strobe (drives in_rd)
mem_wr_addr  output  PSIZE  memory write address
mem_rd_addr  output  PSIZE  memory read address
mem_wdata  output  WIDTH  memory write data
mem_rdata  input  WIDTH  memory registered read data (out_data)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): state = IDLE; all outputs 0, except req_ready = 1 once rst_n is high. Both mem addresses, mem_wdata and rsp_rdata are 0. The latency counter is 0.
- Reset mid-operation: any in-flight request is dropped with no response. Any pending rsp_valid clears immediately.
- All outputs are registered, with no combinational path from inputs to outputs. Exception: req_ready = (state == IDLE), decoded from the state register.
- States: IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch req_wr, req_addr and req_wdata.
  - Write: go to ISSUE_WR. Read: go to ISSUE_RD.
- ISSUE_WR (exactly 1 cycle):
  - mem_wr = 1; mem_wr_addr = latched addr; mem_wdata = latched data, unmodified (the memory applies the swap).
  - Next state RESP with rsp_wr = 1 and rsp_rdata = 0.
- ISSUE_RD (exactly 1 cycle):
  - mem_rd = 1; mem_rd_addr = latched addr.
  - Counter loads RD_LATENCY. Next state WAIT_RD.
- WAIT_RD:
  - Counter decrements each cycle.
  - When the counter reaches 1, sample mem_rdata at that edge and go to RESP.
  - With RD_LATENCY = 1, WAIT_RD lasts exactly 1 cycle.
- Unswap on capture:
  - addr < DEPTH/2: rsp_rdata = mem_rdata.
  - addr >= DEPTH/2: rsp_rdata = {mem_rdata[WIDTH/2-1:0], mem_rdata[WIDTH-1:WIDTH/2]}.
  - The address compare uses the full PSIZE-bit latched addr.
- RESP:
  - rsp_valid = 1; rsp_wr and rsp_rdata are held stable until rsp_ready is sampled high.
  - Then rsp_valid = 0 and the next state is IDLE. No back-to-back bypass.
- Latency, accept edge = E0:
  - Write: mem_wr high in cycle E0..E1; rsp_valid from E1.
  - Read: mem_rd high E0..E1; capture at E1+RD_LATENCY; rsp_valid from E1+RD_LATENCY.
- Memory-side invariants:
  - mem_wr & mem_rd is never 1 in any cycle.
  - Each strobe is a single-cycle pulse per request.
  - mem_wr_addr, mem_rd_addr and mem_wdata hold their last value when the strobes are low.
- req_valid is ignored outside IDLE; a client holding req_valid is accepted on the first IDLE cycle.
- The memory clears synchronously while rst_n is low. Any read after reset therefore returns 0 until written.

Test Plan:
- Write 0xABCD to addr 3, then read addr 3 -> exactly one mem_wr pulse with mem_wdata = 0xABCD; mem_rdata = 0xABCD; rsp_rdata = 0xABCD; rsp_wr = 0 on the read response.
- Write 0x1234 to addr 9, then read addr 9 -> memory holds 0x3412; rsp_rdata = 0x1234. Repeat at boundary addrs 7 (no swap, mem holds 0x1234) and 8 (swap), and at addr 15.
- Read addr 5 directly after reset release -> rsp_rdata = 0x0000; accept-to-rsp_valid = 2 cycles at RD_LATENCY = 1; rerun with RD_LATENCY = 3 -> 4 cycles.
- Hold rsp_ready = 0 for 5 cycles during a read response -> rsp_valid, rsp_rdata and rsp_wr stable; req_ready = 0; busy = 1; no mem strobes issued.
- 200 random write/read requests over all addrs with random rsp_ready stalls -> every read returns the last data written to that addr; mem_wr & mem_rd never simultaneously high.
- Assert rst_n low during WAIT_RD -> rsp_valid, mem_rd and busy all 0 immediately; no response is produced; the next read of a previously written addr returns 0x0000.
